// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: state encoding and
// default values for the PC, PC increment and the bubble instruction.
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_WAIT   = 2'd1,
    ST_VALID  = 2'd2,
    ST_HALTED = 2'd3
  } fetch_state_e;

  localparam logic [15:0] RESET_PC_DEF  = 16'h0000;
  localparam logic [15:0] PC_INC_DEF    = 16'd2;
  localparam logic [15:0] NOP_INSTR_DEF = 16'h0800;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus: req/ready request handshake plus
// an rvalid-qualified response. Fetch is the master, memory the slave.
interface fetch_stage_if;
  logic        req;
  logic [15:0] addr;
  logic        ready;
  logic        rvalid;
  logic [15:0] rdata;

  modport master (output req, addr, input ready, rvalid, rdata);
  modport slave  (input req, addr, output ready, rvalid, rdata);
endinterface

// File: rtl/fetch_stage_pc_reg.sv
// 16-bit address register with synchronous reset and enable; loads either an
// explicit value or its own value plus INC (wrapping modulo 2^16).
module fetch_stage_pc_reg #(
  parameter logic [15:0] RESET_VAL = 16'h0000,
  parameter logic [15:0] INC       = 16'd2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic [15:0] q
);

  // NOTE: non-blocking assignment so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst)
      q <= RESET_VAL;
    else if (en)
      q <= load ? load_val : q + INC;
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues one imem request at a time and
// presents the fetched word to decode until it is accepted.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [15:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [15:0] PC_INC    = PC_INC_DEF,
  parameter logic [15:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 halt,
  input  logic                 redirect_valid,
  input  logic [15:0]          redirect_pc,
  fetch_stage_if.master        imem,
  output logic                 instr_valid,
  output logic [15:0]          instruction,
  output logic [15:0]          pc_out,
  output logic [15:0]          pc_plus2,
  output logic                 halted,
  output logic                 err
);

  fetch_state_e state;
  logic         squash;
  logic [15:0]  pc;
  logic [15:0]  req_pc;
  logic [15:0]  instr_q;
  logic         redirect_eff;
  logic         fetch_accept;
  logic         resp_take;

  assign redirect_eff = redirect_valid && (state != ST_HALTED);
  // A redirect in FETCH suppresses the request so the stale PC never reaches memory.
  assign imem.req     = !rst && (state == ST_FETCH) && !redirect_valid;
  assign imem.addr    = pc;
  assign fetch_accept = imem.req && imem.ready;
  assign resp_take    = (state == ST_WAIT) && imem.rvalid && !squash && !redirect_valid;

  fetch_stage_pc_reg #(.RESET_VAL(RESET_PC), .INC(PC_INC)) u_pc (
    .clk(clk), .rst(rst), .en(fetch_accept || redirect_eff), .load(redirect_eff),
    .load_val(redirect_pc), .q(pc)
  );

  fetch_stage_pc_reg #(.RESET_VAL(16'h0000), .INC(PC_INC)) u_req_pc (
    .clk(clk), .rst(rst), .en(fetch_accept), .load(1'b1), .load_val(pc), .q(req_pc)
  );

  fetch_stage_pc_reg #(.RESET_VAL(16'h0000), .INC(PC_INC)) u_pc_out (
    .clk(clk), .rst(rst), .en(resp_take), .load(1'b1), .load_val(req_pc), .q(pc_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_FETCH;
      squash  <= 1'b0;
      // NOTE: instr_q is masked while invalid, but resetting it keeps X out of debug views.
      instr_q <= NOP_INSTR;
      err     <= 1'b0;
    end else begin
      err <= imem.rvalid && (state != ST_WAIT);
      unique case (state)
        ST_FETCH:
          if (fetch_accept) state <= ST_WAIT;
        ST_WAIT:
          // A redirect coinciding with the response drops it rather than waiting forever.
          if (imem.rvalid) begin
            squash <= 1'b0;
            state  <= (squash || redirect_valid) ? ST_FETCH : ST_VALID;
            if (resp_take) instr_q <= imem.rdata;
          end else if (redirect_valid) begin
            squash <= 1'b1;
          end
        ST_VALID:
          if (redirect_valid)
            state <= ST_FETCH;
          else if (!stall)
            state <= halt ? ST_HALTED : ST_FETCH;
        ST_HALTED: ;
        default: state <= ST_FETCH;
      endcase
    end
  end

  assign instr_valid = (state == ST_VALID);
  assign halted      = (state == ST_HALTED);
  assign instruction = instr_valid ? instr_q : NOP_INSTR;
  assign pc_plus2    = pc_out + PC_INC;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, hand-written corner sequences,
// then randomized traffic against a transaction-level reference model.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        halt = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        instr_valid;
  logic [15:0] instruction;
  logic [15:0] pc_out;
  logic [15:0] pc_plus2;
  logic        halted;
  logic        err;

  fetch_stage_if imem();

  int total = 0;
  int bad   = 0;
  bit auto_mem = 1'b0;
  logic [15:0] const_rdata = 16'hC123;

  typedef struct {
    logic        stall;
    logic        ready;
    logic        exp_req;
    logic [15:0] exp_addr;
    logic        exp_iv;
    logic [15:0] exp_pc_out;
  } vec_t;

  vec_t vecs[9];

  // reference model: what has been requested, what is presented, what is owed
  logic [15:0] m_pc, m_reqpc, m_wpc, m_word;
  bit m_out = 1'b0, m_squash = 1'b0, m_pres = 1'b0, m_halted = 1'b0, m_err = 1'b0;
  bit m_idle;
  logic exp_req;
  logic [15:0] exp_instr;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .halt(halt),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .imem(imem),
    .instr_valid(instr_valid), .instruction(instruction), .pc_out(pc_out),
    .pc_plus2(pc_plus2), .halted(halted), .err(err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one clock; the behavioural memory answers an accepted request one cycle later.
  task automatic tick();
    logic acc;
    acc = imem.req && imem.ready;
    @(posedge clk);
    #1;
    if (auto_mem) begin
      imem.rvalid = acc;
      imem.rdata  = const_rdata;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b0, 1'b1, 1'b1, 16'h0000, 1'b0, 16'h0000};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0000};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 16'h0002, 1'b0, 16'h0000};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0002};
    vecs[6] = '{1'b0, 1'b1, 1'b1, 16'h0004, 1'b0, 16'h0002};
    vecs[7] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0002};
    vecs[8] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0004};

    imem.ready = 1'b1; imem.rvalid = 1'b0; imem.rdata = 16'h0000;

    // reset state, with ready high to show the request is held off
    tick(); tick();
    #1;
    check("rst_req", 64'(imem.req), 64'(0));
    check("rst_iv", 64'(instr_valid), 64'(0));
    check("rst_instr", 64'(instruction), 64'(16'h0800));
    check("rst_pc_out", 64'(pc_out), 64'(0));
    check("rst_halted", 64'(halted), 64'(0));
    check("rst_err", 64'(err), 64'(0));
    rst = 1'b0;
    auto_mem = 1'b1;

    // nominal stream, one instruction per three cycles
    for (int i = 0; i < 9; i++) begin
      stall = vecs[i].stall;
      imem.ready = vecs[i].ready;
      #1;
      check($sformatf("s1_req[%0d]", i), 64'(imem.req), 64'(vecs[i].exp_req));
      if (vecs[i].exp_req)
        check($sformatf("s1_addr[%0d]", i), 64'(imem.addr), 64'(vecs[i].exp_addr));
      check($sformatf("s1_iv[%0d]", i), 64'(instr_valid), 64'(vecs[i].exp_iv));
      check($sformatf("s1_instr[%0d]", i), 64'(instruction),
            64'(vecs[i].exp_iv ? 16'hC123 : 16'h0800));
      check($sformatf("s1_pc_out[%0d]", i), 64'(pc_out), 64'(vecs[i].exp_pc_out));
      check($sformatf("s1_pc_plus2[%0d]", i), 64'(pc_plus2), 64'(vecs[i].exp_pc_out + 16'd2));
      tick();
    end

    // stall holds the presented word and blocks new requests
    tick(); tick();
    stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("s2_iv[%0d]", k), 64'(instr_valid), 64'(1));
      check($sformatf("s2_instr[%0d]", k), 64'(instruction), 64'(16'hC123));
      check($sformatf("s2_pc_out[%0d]", k), 64'(pc_out), 64'(16'h0006));
      check($sformatf("s2_req[%0d]", k), 64'(imem.req), 64'(0));
      tick();
    end
    stall = 1'b0;
    tick();
    #1;
    check("s2_next_req", 64'(imem.req), 64'(1));
    check("s2_next_addr", 64'(imem.addr), 64'(16'h0008));

    // redirect while waiting: the late word is squashed
    auto_mem = 1'b0;
    tick();
    redirect_valid = 1'b1; redirect_pc = 16'h0040;
    #1;
    check("s3_wait_req", 64'(imem.req), 64'(0));
    tick();
    redirect_valid = 1'b0;
    imem.rvalid = 1'b1; imem.rdata = 16'hDEAD;
    #1;
    check("s3_squash_iv", 64'(instr_valid), 64'(0));
    tick();
    imem.rvalid = 1'b0; imem.ready = 1'b0;
    #1;
    check("s3_iv", 64'(instr_valid), 64'(0));
    check("s3_req", 64'(imem.req), 64'(1));
    check("s3_addr", 64'(imem.addr), 64'(16'h0040));
    check("s3_err", 64'(err), 64'(0));

    // stray response in FETCH: one-cycle err, nothing else moves
    imem.rvalid = 1'b1;
    tick();
    imem.rvalid = 1'b0;
    #1;
    check("s6_err_hi", 64'(err), 64'(1));
    check("s6_req", 64'(imem.req), 64'(1));
    check("s6_addr", 64'(imem.addr), 64'(16'h0040));
    tick();
    #1;
    check("s6_err_lo", 64'(err), 64'(0));
    check("s6_addr2", 64'(imem.addr), 64'(16'h0040));

    // PC wrap at the top of the address space
    redirect_valid = 1'b1; redirect_pc = 16'hFFFE;
    #1;
    check("s4_redirect_req", 64'(imem.req), 64'(0));
    tick();
    redirect_valid = 1'b0; imem.ready = 1'b1; auto_mem = 1'b1;
    #1;
    check("s4_addr", 64'(imem.addr), 64'(16'hFFFE));
    tick(); tick();
    #1;
    check("s4_iv", 64'(instr_valid), 64'(1));
    check("s4_pc_out", 64'(pc_out), 64'(16'hFFFE));
    check("s4_pc_plus2", 64'(pc_plus2), 64'(16'h0000));
    tick();
    #1;
    check("s4_wrap_addr", 64'(imem.addr), 64'(16'h0000));

    // halt, then only reset restarts fetch
    tick(); tick();
    halt = 1'b1;
    #1;
    check("s5_iv", 64'(instr_valid), 64'(1));
    tick();
    halt = 1'b0;
    for (int k = 0; k < 10; k++) begin
      redirect_valid = (k == 3);
      redirect_pc = 16'h1234;
      #1;
      check($sformatf("s5_halted[%0d]", k), 64'(halted), 64'(1));
      check($sformatf("s5_req[%0d]", k), 64'(imem.req), 64'(0));
      check($sformatf("s5_iv[%0d]", k), 64'(instr_valid), 64'(0));
      tick();
    end
    redirect_valid = 1'b0;
    auto_mem = 1'b0;
    #1;
    check("s5_pc_frozen", 64'(imem.addr), 64'(16'h0002));
    imem.rvalid = 1'b1;
    tick();
    imem.rvalid = 1'b0;
    #1;
    check("s5_err", 64'(err), 64'(1));
    rst = 1'b1;
    #1;
    check("s5_rst_req", 64'(imem.req), 64'(0));
    tick();
    rst = 1'b0;
    #1;
    check("s5_restart_req", 64'(imem.req), 64'(1));
    check("s5_restart_addr", 64'(imem.addr), 64'(RESET_PC_DEF));
    check("s5_restart_halted", 64'(halted), 64'(0));

    // reset while a request is outstanding; the late response is a protocol error
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; imem.ready = 1'b0; imem.rvalid = 1'b1;
    #1;
    tick();
    imem.rvalid = 1'b0;
    #1;
    check("rw_err", 64'(err), 64'(1));
    check("rw_req", 64'(imem.req), 64'(1));
    check("rw_addr", 64'(imem.addr), 64'(RESET_PC_DEF));

    // randomized traffic against the reference model
    for (int c = 0; c < 3000; c++) begin
      rst            = (c == 0) || ($urandom_range(99) == 0);
      stall          = ($urandom_range(3) == 0);
      halt           = ($urandom_range(19) == 0);
      redirect_valid = ($urandom_range(15) == 0);
      redirect_pc    = 16'($urandom) & 16'hFFFE;
      imem.ready     = ($urandom_range(3) != 0);
      imem.rvalid    = m_out ? ($urandom_range(2) != 0) : ($urandom_range(29) == 0);
      imem.rdata     = 16'($urandom);
      #1;
      m_idle    = !m_out && !m_pres && !m_halted;
      exp_req   = !rst && m_idle && !redirect_valid;
      exp_instr = m_pres ? m_word : 16'h0800;
      if (c > 0) begin
        check($sformatf("rnd_ctl[%0d]", c),
              64'({imem.req, instr_valid, halted, err, imem.addr}),
              64'({exp_req, m_pres, m_halted, m_err, m_pc}));
        check($sformatf("rnd_data[%0d]", c),
              64'({instruction, pc_out, pc_plus2}),
              64'({exp_instr, m_wpc, 16'(m_wpc + 16'd2)}));
      end
      if (rst) begin
        m_pc = RESET_PC_DEF; m_reqpc = 16'h0000; m_wpc = 16'h0000; m_word = 16'h0800;
        m_out = 1'b0; m_squash = 1'b0; m_pres = 1'b0; m_halted = 1'b0; m_err = 1'b0;
      end else begin
        m_err = imem.rvalid && !m_out;
        if (m_halted) begin
          // frozen until reset
        end else if (m_idle) begin
          if (redirect_valid) m_pc = redirect_pc;
          else if (imem.ready) begin
            m_reqpc = m_pc; m_pc = m_pc + 16'd2; m_out = 1'b1;
          end
        end else if (m_out) begin
          if (imem.rvalid) begin
            m_out = 1'b0;
            if (!m_squash && !redirect_valid) begin
              m_pres = 1'b1; m_word = imem.rdata; m_wpc = m_reqpc;
            end
            m_squash = 1'b0;
            if (redirect_valid) m_pc = redirect_pc;
          end else if (redirect_valid) begin
            m_squash = 1'b1; m_pc = redirect_pc;
          end
        end else begin
          if (redirect_valid) begin
            m_pres = 1'b0; m_pc = redirect_pc;
          end else if (!stall) begin
            m_pres = 1'b0;
            if (halt) m_halted = 1'b1;
          end
        end
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
